ser_byte_collector: RTL and testbench
=====================================

SER_BYTE_COLLECTOR -- requirements
Module: ser_byte_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning parallel word width in bits (legal values 2..16).
REQ-002 SHALL have port clk, input, 1, meaning the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning reset: synchronous, active-high.
REQ-004 SHALL have port clkEn, input, 1, meaning sample enable; serial inputs are sampled only on edges where clkEn=1.
REQ-005 SHALL have port serIn, input, 1, meaning serial data bit from the upstream sequence detector (its serOut).
REQ-006 SHALL have port serInValid, input, 1, meaning serIn carries a payload bit (upstream serOutValid).
REQ-007 SHALL have port ack, input, 1, meaning the consumer accepts dataOut; sampled every clk, not gated by clkEn.
REQ-008 SHALL have port dataOut, output, WIDTH, meaning the last completed word, MSB received first.
REQ-009 SHALL have port dataValid, output, 1, meaning dataOut holds an unacknowledged word.
REQ-010 SHALL have port bitCnt, output, clog2(WIDTH), meaning the number of bits collected in the current partial word.
REQ-011 SHALL have port frameEnd, output, 1, meaning a one-clk pulse when an upstream frame ends.
REQ-012 SHALL have port partialDrop, output, 1, meaning a one-clk pulse when a frame ends with a partial word discarded.
REQ-013 SHALL have port overrun, output, 1, meaning sticky flag: a completed word was lost.

Function
REQ-014 SHALL implement a 2-state FSM: IDLE (no frame active) and RECV (frame active).
REQ-015 IDLE -> RECV SHALL occur on an edge with clkEn=1 and serInValid=1; that bit is collected on the same edge.
REQ-016 RECV -> IDLE SHALL occur on an edge with clkEn=1 and serInValid=0; frameEnd=1 for exactly the following cycle.
REQ-017 On every collected bit, shift register SHALL update as sh <= {sh[WIDTH-2:0], serIn} and bitCnt SHALL increment.
REQ-018 When bitCnt=WIDTH-1 and a bit is collected, the word {sh[WIDTH-2:0], serIn} SHALL complete and bitCnt SHALL wrap to 0.
REQ-019 On completion with dataValid=0, or with dataValid=1 and ack=1 on the same edge, dataOut SHALL load the word and dataValid SHALL be 1 on the next cycle.
REQ-020 On completion with dataValid=1 and ack=0, the new word SHALL be dropped, dataOut SHALL be unchanged and overrun SHALL set.
REQ-021 ack=1 with dataValid=1 and no completion SHALL clear dataValid on the next cycle; ack with dataValid=0 SHALL be ignored.
REQ-022 On RECV -> IDLE with bitCnt!=0, partial bits SHALL be discarded, bitCnt SHALL be 0, and partialDrop SHALL pulse together with frameEnd.
REQ-023 Edges with clkEn=0 SHALL leave the FSM, sh and bitCnt unchanged, while ack handling per REQ-021 still applies.
REQ-024 overrun SHALL remain 1 until rst; it SHALL NOT be cleared by ack.
REQ-025 frameEnd and partialDrop SHALL be registered outputs, each high for at most one clk per frame end.

Reset
REQ-026 While rst=1 on a clk edge, next state SHALL be IDLE with sh=0, bitCnt=0, dataOut=0, dataValid=0, frameEnd=0, partialDrop=0 and overrun=0.
REQ-027 rst SHALL take priority over all inputs, including mid-frame and with dataValid=1; any pending word and partial bits SHALL be lost.

Verification
REQ-028 SHALL test: WIDTH=8, clkEn=1 every clk, serInValid=1 for 8 bits 1,0,1,1,0,0,1,0, then serInValid=0 -> dataOut=8'hB2 and dataValid=1 one cycle after the 8th bit, frameEnd pulse one cycle after serInValid drops, partialDrop=0.
REQ-029 SHALL test: same 8 bits with clkEn=1 only every 4th clk -> identical dataOut=8'hB2, bitCnt advances only on enabled edges.
REQ-030 SHALL test: 16 bits forming 8'h5A then 8'hC3, no ack -> dataOut stays 8'h5A and overrun=1; repeat with ack on the 16th-bit edge -> dataOut=8'hC3, dataValid stays 1, overrun=0.
REQ-031 SHALL test: frame of 11 bits -> one word output, bitCnt=3 before the frame ends, then frameEnd and partialDrop pulse together and bitCnt=0.
REQ-032 SHALL test: rst asserted after bit 5 of a frame with dataValid=1 -> all outputs 0 next cycle; a subsequent clean 8-bit frame produces a correct word.

Source files
------------

// File: rtl/ser_byte_collector.sv
// -----------------------------------------------------------------------------
// ser_byte_collector
//
// Collects payload bits from an upstream serial source into WIDTH-bit parallel
// words, MSB first. A frame is a run of enabled edges with serInValid=1. The
// frame closes on the first enabled edge with serInValid=0. Bits left over at
// the end of a frame are discarded. Completed words are held in a single
// output register until the consumer acknowledges them.
//
// Parameters
//   WIDTH        parallel word width in bits (2..16)
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous, active-high reset; overrides every other input
//   clkEn        sample enable for serIn/serInValid (ack is not gated by it)
//   serIn        serial payload bit
//   serInValid   serIn carries a payload bit; low on an enabled edge ends a frame
//   ack          consumer accepts dataOut (sampled every clk)
//   dataOut      last completed word
//   dataValid    dataOut holds a word that has not been acknowledged
//   bitCnt       number of bits in the current partial word
//   frameEnd     one-clk pulse after a frame closes
//   partialDrop  one-clk pulse, coincident with frameEnd, when bits were lost
//   overrun      sticky: a completed word was dropped because dataOut was full
// -----------------------------------------------------------------------------
module ser_byte_collector #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clkEn,
  input  logic                     serIn,
  input  logic                     serInValid,
  input  logic                     ack,
  output logic [WIDTH-1:0]         dataOut,
  output logic                     dataValid,
  output logic [$clog2(WIDTH)-1:0] bitCnt,
  output logic                     frameEnd,
  output logic                     partialDrop,
  output logic                     overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,  // no frame active
    RECV = 1'b1   // frame active, collecting bits
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh;

  // Decoded events for the current edge.
  logic             collect;    // a payload bit is taken on this edge
  logic             close;      // the active frame ends on this edge
  logic             complete;   // this bit finishes a word
  logic             can_load;   // output register is free (or being freed)
  logic [WIDTH-1:0] word;       // word formed if this bit completes it

  // NOTE: every signal driven from always_comb gets a default first so no
  // path through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    collect  = 1'b0;
    close    = 1'b0;
    complete = 1'b0;
    can_load = 1'b0;
    word     = {sh[WIDTH-2:0], serIn};

    if (clkEn) begin
      // A valid bit is collected in either state: the bit that opens a
      // frame belongs to that frame.
      collect = serInValid;
      close   = (state == RECV) && !serInValid;
    end
    complete = collect && (bitCnt == LAST_BIT);
    // A word the consumer acks on the same edge makes room for the new one.
    can_load = !dataValid || ack;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sh          <= '0;
      bitCnt      <= '0;
      dataOut     <= '0;
      dataValid   <= 1'b0;
      frameEnd    <= 1'b0;
      partialDrop <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      // Pulses default low; they are raised only on the edge that closes
      // a frame, so each lasts exactly one cycle.
      frameEnd    <= 1'b0;
      partialDrop <= 1'b0;

      // Acknowledge handling runs every cycle, independent of clkEn. A
      // completion below may re-assert dataValid on the same edge.
      if (dataValid && ack) begin
        dataValid <= 1'b0;
      end

      // Frame state.
      case (state)
        IDLE: begin
          if (collect) begin
            state <= RECV;
          end
        end
        RECV: begin
          if (close) begin
            state       <= IDLE;
            frameEnd    <= 1'b1;
            partialDrop <= (bitCnt != '0);
          end
        end
        default: state <= IDLE;
      endcase

      // Bit collection.
      if (collect) begin
        sh <= word;
        if (complete) begin
          bitCnt <= '0;
        end else begin
          bitCnt <= bitCnt + CW'(1);
        end
      end else if (close) begin
        // Discard any partial word so the next frame starts clean.
        sh     <= '0;
        bitCnt <= '0;
      end

      // Word hand-off: load if the output register is free, otherwise
      // drop the new word and remember that it happened.
      if (complete) begin
        if (can_load) begin
          dataOut   <= word;
          dataValid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ser_byte_collector.sv
module tb_ser_byte_collector;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             clkEn;
  logic             serIn;
  logic             serInValid;
  logic             ack;
  logic [WIDTH-1:0] dataOut;
  logic             dataValid;
  logic [2:0]       bitCnt;
  logic             frameEnd;
  logic             partialDrop;
  logic             overrun;

  int n_vec = 0;
  int n_err = 0;

  ser_byte_collector #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .clkEn       (clkEn),
    .serIn       (serIn),
    .serInValid  (serInValid),
    .ack         (ack),
    .dataOut     (dataOut),
    .dataValid   (dataValid),
    .bitCnt      (bitCnt),
    .frameEnd    (frameEnd),
    .partialDrop (partialDrop),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one enabled payload bit and clock it in.
  task automatic send_bit(input logic b);
    clkEn      = 1'b1;
    serInValid = 1'b1;
    serIn      = b;
    step();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  // Enabled edge with serInValid=0: closes an active frame.
  task automatic end_frame();
    clkEn      = 1'b1;
    serInValid = 1'b0;
    serIn      = 1'b0;
    step();
  endtask

  task automatic do_ack();
    clkEn      = 1'b0;
    serInValid = 1'b0;
    ack        = 1'b1;
    step();
    ack        = 1'b0;
  endtask

  initial begin
    logic [7:0] pat_b2;
    logic [7:0] pat_c3;
    pat_b2 = 8'hB2;
    pat_c3 = 8'hC3;

    rst = 1'b1; clkEn = 1'b1; serIn = 1'b1; serInValid = 1'b1; ack = 1'b0;

    // ---- reset state ----
    step();
    check("rst_dataOut",     dataOut,     0);
    check("rst_dataValid",   dataValid,   0);
    check("rst_bitCnt",      bitCnt,      0);
    check("rst_frameEnd",    frameEnd,    0);
    check("rst_partialDrop", partialDrop, 0);
    check("rst_overrun",     overrun,     0);
    rst = 1'b0;
    end_frame();  // idle edge, nothing active
    check("idle_frameEnd", frameEnd, 0);

    // ---- basic 8-bit frame, clkEn every clk: 1,0,1,1,0,0,1,0 = B2 ----
    for (int i = 7; i >= 5; i--) send_bit(pat_b2[i]);
    check("t1_bitCnt3", bitCnt, 3);
    for (int i = 4; i >= 1; i--) send_bit(pat_b2[i]);
    check("t1_valid_before8", dataValid, 0);
    send_bit(pat_b2[0]);
    check("t1_dataOut",   dataOut,   8'hB2);
    check("t1_dataValid", dataValid, 1);
    check("t1_bitCnt0",   bitCnt,    0);
    check("t1_frameEnd_early", frameEnd, 0);
    end_frame();
    check("t1_frameEnd",    frameEnd,    1);
    check("t1_partialDrop", partialDrop, 0);
    end_frame();
    check("t1_frameEnd_pulse", frameEnd, 0);
    do_ack();
    check("t1_ack_clears", dataValid, 0);
    do_ack();
    check("t1_ack_idle_ignored", dataValid, 0);

    // ---- same bits with clkEn only every 4th clk ----
    for (int i = 7; i >= 0; i--) begin
      send_bit(pat_b2[i]);
      // Disabled edges with serInValid low must neither end the frame
      // nor shift anything in.
      clkEn = 1'b0; serInValid = 1'b0; serIn = ~pat_b2[i];
      for (int k = 0; k < 3; k++) step();
      if (i == 5) begin
        check("t2_bitCnt_hold", bitCnt, 3);
        check("t2_no_frameEnd", frameEnd, 0);
      end
    end
    check("t2_dataOut",   dataOut,   8'hB2);
    check("t2_dataValid", dataValid, 1);
    end_frame();
    check("t2_frameEnd", frameEnd, 1);
    // ack still honoured while clkEn=0
    do_ack();
    check("t2_ack_gated_clk", dataValid, 0);

    // ---- two words 5A, C3, no ack: second word dropped ----
    send_byte(8'h5A);
    check("t3_first", dataOut, 8'h5A);
    send_byte(8'hC3);
    check("t3_dataOut_held", dataOut,   8'h5A);
    check("t3_overrun",      overrun,   1);
    check("t3_valid",        dataValid, 1);
    end_frame();
    do_ack();
    check("t3_overrun_sticky", overrun,   1);
    check("t3_ack_clears",     dataValid, 0);
    rst = 1'b1; step(); rst = 1'b0;
    check("t3_overrun_rst", overrun, 0);

    // ---- repeat with ack on the 16th-bit edge: C3 replaces 5A ----
    send_byte(8'h5A);
    for (int i = 7; i >= 1; i--) send_bit(pat_c3[i]);
    ack = 1'b1;
    send_bit(pat_c3[0]);
    ack = 1'b0;
    check("t3b_dataOut",   dataOut,   8'hC3);
    check("t3b_dataValid", dataValid, 1);
    check("t3b_overrun",   overrun,   0);
    end_frame();
    do_ack();

    // ---- 11-bit frame: one word, 3 bits discarded ----
    send_byte(8'hB2);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("t4_dataOut",   dataOut, 8'hB2);
    check("t4_bitCnt3",   bitCnt,  3);
    check("t4_no_pd_yet", partialDrop, 0);
    end_frame();
    check("t4_frameEnd",    frameEnd,    1);
    check("t4_partialDrop", partialDrop, 1);
    check("t4_bitCnt0",     bitCnt,      0);
    end_frame();
    check("t4_frameEnd_pulse",    frameEnd,    0);
    check("t4_partialDrop_pulse", partialDrop, 0);
    check("t4_dataOut_kept",      dataOut,     8'hB2);
    do_ack();

    // ---- reset mid-frame with a pending word ----
    send_byte(8'h5A);
    end_frame();
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    check("t5_pre_valid",  dataValid, 1);
    check("t5_pre_bitCnt", bitCnt,    5);
    rst = 1'b1;
    send_bit(1'b1);  // rst wins over a valid enabled bit
    rst = 1'b0;
    check("t5_dataOut",     dataOut,     0);
    check("t5_dataValid",   dataValid,   0);
    check("t5_bitCnt",      bitCnt,      0);
    check("t5_frameEnd",    frameEnd,    0);
    check("t5_partialDrop", partialDrop, 0);
    check("t5_overrun",     overrun,     0);
    end_frame();
    check("t5_idle_after_rst", frameEnd, 0);
    send_byte(8'hC3);
    check("t5_clean_word",  dataOut,   8'hC3);
    check("t5_clean_valid", dataValid, 1);
    end_frame();
    check("t5_clean_end", frameEnd,    1);
    check("t5_clean_pd",  partialDrop, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
